memarray_seq: RTL

Operation sequencer for the off-chip memristor array accelerator. Accepts one array operation at a time from the system bus side (program/form, read memory, read register, inference), then drives the chip strobes (CBL, CBLEN, CSL, CWL), instruction code and row/column address through fixed setup, pulse and sample phases. It captures the 4-bit array output and returns it on a valid/ready response channel. Sits inside `pinaipple_system` between the bus-facing accelerator registers and the chip pins.

---
 rtl/memarray_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/memarray_seq.sv
// memarray_seq: single-operation sequencer for the memristor array chip.
// Accepts one request (form/prog, read_mem, read_reg, inference), walks
// SETUP -> PULSE -> SAMPLE timed by one down-counter, captures bit_out
// and returns it on a valid/ready response channel.
// Ports:
//   clk_sys_in, rst_sys_in (sync, active-high)
//   req_*  : request channel (valid/ready, op, col, row, wdata)
//   rsp_*  : response channel (valid/ready, data)
//   busy   : sequencer not idle
//   CBL, CBLEN, CSL, CWL, instructions, addr_col, addr_row : chip pins
//   bit_out: chip data out, one bit per array
// Option: MEMARRAY_SEQ_SYNC_EN adds a 2-flop synchronizer on bit_out
// and stretches SAMPLE by 2 cycles to keep the same capture point.
module memarray_seq #(
  parameter int unsigned SetupCycles  = 2,
  parameter int unsigned PulseCycles  = 4,
  parameter int unsigned SampleCycles = 2
) (
  input  logic       clk_sys_in,
  input  logic       rst_sys_in,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [4:0] req_col,
  input  logic [4:0] req_row,
  input  logic       req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       busy,
  output logic       CBL,
  output logic       CBLEN,
  output logic       CSL,
  output logic       CWL,
  output logic [1:0] instructions,
  output logic [4:0] addr_col,
  output logic [4:0] addr_row,
  input  logic [3:0] bit_out
);

`ifdef MEMARRAY_SEQ_SYNC_EN
  localparam int unsigned CW       = 5;
  localparam int unsigned SmpExtra = 2;
`else
  localparam int unsigned CW       = 4;
  localparam int unsigned SmpExtra = 0;
`endif

  localparam logic [CW-1:0] LdSetup  = CW'(SetupCycles - 1);
  localparam logic [CW-1:0] LdPulse  = CW'(PulseCycles - 1);
  localparam logic [CW-1:0] LdSample = CW'(SampleCycles - 1 + SmpExtra);

  if (SetupCycles < 1 || SetupCycles > 15 ||
      PulseCycles < 1 || PulseCycles > 15 ||
      SampleCycles < 1 || SampleCycles > 15) begin : g_bad_param
    $fatal(1, "memarray_seq: timing parameter out of range 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_SAMPLE, S_RESP
  } state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic       r_req_ready, r_busy, r_rsp_valid;
  logic       r_cbl, r_cblen, r_csl, r_cwl;
  logic [1:0] r_instr;
  logic [4:0] r_col, r_row;
  logic       r_wdata;
  logic [3:0] r_rsp_data;

  logic       w_accept, w_prog, w_wd, w_pulse, w_drive, w_capture;
  logic [3:0] w_bit;

`ifdef MEMARRAY_SEQ_SYNC_EN
  logic [3:0] r_sync1, r_sync2;

  always_ff @(posedge clk_sys_in) begin
    if (rst_sys_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bit_out;
      r_sync2 <= r_sync1;
    end
  end

  assign w_bit = r_sync2;
`else
  assign w_bit = bit_out;
`endif

  always_ff @(posedge clk_sys_in) begin
    if (rst_sys_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_nxt     = S_SETUP;
          w_cnt_nxt = LdSetup;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_nxt     = S_PULSE;
          w_cnt_nxt = LdPulse;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_nxt     = S_SAMPLE;
          w_cnt_nxt = LdSample;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_SAMPLE: begin
        if (r_cnt == '0) begin
          w_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state; on the accepting edge
  // the op/wdata come straight from the request, later from the latches.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && req_valid;
    w_prog    = w_accept ? (req_op == 2'b11) : (r_instr == 2'b11);
    w_wd      = w_accept ? req_wdata : r_wdata;
    w_pulse   = (w_nxt == S_PULSE);
    w_drive   = w_prog && ((w_nxt == S_SETUP) || (w_nxt == S_PULSE));
    w_capture = (r_state == S_SAMPLE) && (r_cnt == '0);
  end

  always_ff @(posedge clk_sys_in) begin
    if (rst_sys_in) begin
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cbl       <= 1'b0;
      r_cblen     <= 1'b0;
      r_csl       <= 1'b0;
      r_cwl       <= 1'b0;
      r_instr     <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_wdata     <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_req_ready <= (w_nxt == S_IDLE);
      r_busy      <= (w_nxt != S_IDLE);
      r_rsp_valid <= (w_nxt == S_RESP);
      r_csl       <= w_pulse;
      r_cwl       <= w_pulse;
      r_cblen     <= w_drive;
      r_cbl       <= w_drive && w_wd;
      if (w_accept) begin
        r_instr <= req_op;
        r_col   <= req_col;
        r_row   <= req_row;
        r_wdata <= req_wdata;
      end
      if (w_capture) begin
        r_rsp_data <= (r_instr == 2'b11) ? 4'b0000 : w_bit;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign CBL          = r_cbl;
  assign CBLEN        = r_cblen;
  assign CSL          = r_csl;
  assign CWL          = r_cwl;
  assign instructions = r_instr;
  assign addr_col     = r_col;
  assign addr_row     = r_row;

endmodule
